// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and
// op classification helpers.
package alu_mc_pkg;

    // Single-cycle op codes
    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_NOR   = 5'b00101;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLT   = 5'b00111;
    localparam logic [4:0] OP_SLTU  = 5'b01000;
    localparam logic [4:0] OP_SLL   = 5'b01001;
    localparam logic [4:0] OP_SRL   = 5'b01010;
    localparam logic [4:0] OP_SRA   = 5'b01011;
    localparam logic [4:0] OP_SLLV  = 5'b01100;
    localparam logic [4:0] OP_SRLV  = 5'b01101;
    localparam logic [4:0] OP_SRAV  = 5'b01110;

    // Iterative op codes
    localparam logic [4:0] OP_MUL   = 5'b10000;
    localparam logic [4:0] OP_MULH  = 5'b10001;
    localparam logic [4:0] OP_MULHU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b10100;
    localparam logic [4:0] OP_DIVU  = 5'b10101;
    localparam logic [4:0] OP_REM   = 5'b10110;
    localparam logic [4:0] OP_REMU  = 5'b10111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for the ops that run through the shift-add / restoring unit.
    function automatic logic is_iterative(input logic [4:0] op);
        logic r;
        case (op)
            OP_MUL, OP_MULH, OP_MULHU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the divide/remainder group (needs the divide-by-zero bypass).
    function automatic logic is_div_rem(input logic [4:0] op);
        logic r;
        case (op)
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: r = 1'b1;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_multicycle_muldiv.sv
// Iterative multiply/divide unit. One shared 2*WIDTH accumulator serves a
// shift-add multiplier and a restoring divider. Signed ops run on operand
// magnitudes; the final sign correction is applied combinationally on the
// result port during the cycle in which done is high.
module muldiv_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    // One shift-add step: add the multiplicand into the high half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {s, acc[WIDTH-1:1]};
    endfunction

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits, record quotient bit.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0] r;
        logic [WIDTH:0] t;
        logic [2*WIDTH-1:0] nxt;
        r = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        t = r - {1'b0, d};
        if (!t[WIDTH]) begin
            nxt = {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            nxt = {r[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
        return nxt;
    endfunction

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   m_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic               div_q;
    logic               hi_q;
    logic               rem_q;
    logic               neg_q;

    logic               sgn_op_s;
    logic               sa_s;
    logic               sb_s;
    logic [WIDTH-1:0]   ma_s;
    logic [WIDTH-1:0]   mb_s;
    logic               div_op_s;
    logic               neg_s;
    logic [2*WIDTH-1:0] init_acc_s;
    logic [WIDTH-1:0]   init_m_s;
    logic [2*WIDTH-1:0] step_src_s;
    logic [WIDTH-1:0]   step_m_s;
    logic               step_div_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   qsel_s;
    logic [WIDTH-1:0]   qfix_s;

    // Decode the incoming op into magnitudes, mode and final-sign flag.
    always_comb begin
        sgn_op_s   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        sa_s       = sgn_op_s & a[WIDTH-1];
        sb_s       = sgn_op_s & b[WIDTH-1];
        ma_s       = sa_s ? ({WIDTH{1'b0}} - a) : a;
        mb_s       = sb_s ? ({WIDTH{1'b0}} - b) : b;
        div_op_s   = op[2];
        neg_s      = (op == OP_REM) ? sa_s : (sa_s ^ sb_s);
        init_acc_s = {{WIDTH{1'b0}}, (div_op_s ? ma_s : mb_s)};
        init_m_s   = div_op_s ? mb_s : ma_s;
    end

    // Select the step source; the start edge already performs the first step.
    always_comb begin
        if (start) begin
            step_src_s = init_acc_s;
            step_m_s   = init_m_s;
            step_div_s = div_op_s;
        end else begin
            step_src_s = acc_q;
            step_m_s   = m_q;
            step_div_s = div_q;
        end
        acc_next_s = step_div_s ? div_step(step_src_s, step_m_s)
                                : mul_step(step_src_s, step_m_s);
    end

    // Accumulator, iteration counter and latched op attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= {(2*WIDTH){1'b0}};
            m_q   <= {WIDTH{1'b0}};
            cnt_q <= {CW{1'b0}};
            run_q <= 1'b0;
            div_q <= 1'b0;
            hi_q  <= 1'b0;
            rem_q <= 1'b0;
            neg_q <= 1'b0;
        end else if (start) begin
            acc_q <= acc_next_s;
            m_q   <= init_m_s;
            cnt_q <= CNT_ONE;
            run_q <= 1'b1;
            div_q <= div_op_s;
            hi_q  <= (op == OP_MULH) || (op == OP_MULHU);
            rem_q <= (op == OP_REM) || (op == OP_REMU);
            neg_q <= neg_s;
        end else if (run_q) begin
            if (cnt_q == CNT_LAST) begin
                run_q <= 1'b0;
            end else begin
                acc_q <= acc_next_s;
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign done = run_q && (cnt_q == CNT_LAST);

    // Sign-fix and half/quotient/remainder selection of the finished result.
    always_comb begin
        prod_s = neg_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        qsel_s = rem_q ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        qfix_s = neg_q ? ({WIDTH{1'b0}} - qsel_s) : qsel_s;
        if (div_q) begin
            result = qfix_s;
        end else if (hi_q) begin
            result = prod_s[2*WIDTH-1:WIDTH];
        end else begin
            result = prod_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake. Single-cycle ops and
// divide-by-zero resolve on the accepting edge; MUL*/DIV*/REM* go through
// muldiv_iter. All result outputs are registered and held until consumed.
module alu_multicycle
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op_code,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [SHW-1:0]   shamt,
    input  logic             overflow_check,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero_flag,
    output logic             overflow
);

    state_e           state_q;
    state_e           state_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic             zero_q;
    logic             zero_d;
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] sc_res_s;
    logic             sc_ovf_s;
    logic             div_zero_s;
    logic             launch_iter_s;
    logic             accept_s;
    logic             start_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_res_s;

    assign in_ready      = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_s      = in_valid && in_ready && !flush;
    assign div_zero_s    = is_div_rem(op_code) && (srcb == {WIDTH{1'b0}});
    assign launch_iter_s = is_iterative(op_code) && !div_zero_s;

    // Single-cycle datapath, also producing the divide-by-zero results.
    always_comb begin
        sum_s    = srca + srcb;
        diff_s   = srca - srcb;
        sc_ovf_s = 1'b0;
        case (op_code)
            OP_AND:  sc_res_s = srca & srcb;
            OP_OR:   sc_res_s = srca | srcb;
            OP_ADD:  begin
                sc_res_s = sum_s;
                sc_ovf_s = overflow_check && (srca[WIDTH-1] == srcb[WIDTH-1])
                                          && (sum_s[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_XOR:  sc_res_s = srca ^ srcb;
            OP_NOR:  sc_res_s = ~(srca | srcb);
            OP_SUB:  begin
                sc_res_s = diff_s;
                sc_ovf_s = overflow_check && (srca[WIDTH-1] != srcb[WIDTH-1])
                                          && (diff_s[WIDTH-1] != srca[WIDTH-1]);
            end
            OP_SLT:  sc_res_s = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            OP_SLTU: sc_res_s = {{(WIDTH-1){1'b0}}, (srca < srcb)};
            OP_SLL:  sc_res_s = srcb << shamt;
            OP_SRL:  sc_res_s = srcb >> shamt;
            OP_SRA:  sc_res_s = $signed(srcb) >>> shamt;
            OP_SLLV: sc_res_s = srcb << srca[SHW-1:0];
            OP_SRLV: sc_res_s = srcb >> srca[SHW-1:0];
            OP_SRAV: sc_res_s = $signed(srcb) >>> srca[SHW-1:0];
            OP_DIV, OP_DIVU: sc_res_s = {WIDTH{1'b1}};
            OP_REM, OP_REMU: sc_res_s = srca;
            default: sc_res_s = srca;
        endcase
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .op     (op_code),
        .a      (srca),
        .b      (srcb),
        .done   (md_done_s),
        .result (md_res_s)
    );

    // Next-state and output-register update; flush beats any accept.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        start_s     = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            if (launch_iter_s) begin
                state_d     = BUSY;
                out_valid_d = 1'b0;
                start_s     = 1'b1;
            end else begin
                state_d     = DONE;
                out_valid_d = 1'b1;
                res_d       = sc_res_s;
                zero_d      = (sc_res_s == {WIDTH{1'b0}});
                ovf_d       = sc_ovf_s;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                BUSY: begin
                    if (md_done_s) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        res_d       = md_res_s;
                        zero_d      = (md_res_s == {WIDTH{1'b0}});
                        ovf_d       = 1'b0;
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= {WIDTH{1'b0}};
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_res   = res_q;
    assign zero_flag = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a vector table run back-to-back through a
// scoreboard, then hand-written hold, back-to-back, flush and reset sequences.
module tb_alu_multicycle;
    import alu_mc_pkg::*;

    localparam int W     = 32;
    localparam int LIMIT = 100;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    op_code;
    logic [W-1:0]  srca;
    logic [W-1:0]  srcb;
    logic [4:0]    shamt;
    logic          overflow_check;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  alu_res;
    logic          zero_flag;
    logic          overflow;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic         ovc;
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    alu_multicycle #(.WIDTH(W), .SHW(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op_code        (op_code),
        .srca           (srca),
        .srcb           (srcb),
        .shamt          (shamt),
        .overflow_check (overflow_check),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_res        (alu_res),
        .zero_flag      (zero_flag),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] sh, input logic ovc, input logic [W-1:0] res,
                           input logic ovf, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.sh = sh; v.ovc = ovc;
        v.res = res; v.ovf = ovf; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Scoreboard: every consumed result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got 0x%h required no output", alu_res);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", alu_res, mon_e.res);
                check("zero_flag", 32'(zero_flag), 32'(mon_e.res == 32'h0));
                check("overflow", 32'(overflow), 32'(mon_e.ovf));
            end
        end
    end

    // Issue one op (caller starts just after a rising edge) and measure latency.
    task automatic run_op(input vec_t v);
        exp_t e;
        int   lat;
        bit   busy_rdy;
        op_code        = v.op;
        srca           = v.a;
        srcb           = v.b;
        shamt          = v.sh;
        overflow_check = v.ovc;
        in_valid       = 1'b1;
        e.res = v.res;
        e.ovf = v.ovf;
        sb_q.push_back(e);
        #1;
        check("in_ready_at_issue", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < LIMIT) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(v.lat));
        if (v.lat > 1) check("in_ready_busy", 32'(busy_rdy), 32'h0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        vec_t v;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op_code = 5'd0;
        srca = 32'h0; srcb = 32'h0; shamt = 5'd0; overflow_check = 1'b0; out_ready = 1'b1;

        add_vec(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b1, 32'h80000000, 1'b1, 1);
        add_vec(OP_SUB,   32'h00000005, 32'h00000005, 5'd0,  1'b1, 32'h00000000, 1'b0, 1);
        add_vec(OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000000, 1'b0, 1);
        add_vec(OP_SLT,   32'hFFFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h00000001, 1'b0, 1);
        add_vec(OP_SLT,   32'h00000001, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000000, 1'b0, 1);
        add_vec(OP_SRA,   32'h00000000, 32'h80000000, 5'd4,  1'b0, 32'hF8000000, 1'b0, 1);
        add_vec(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hF000F000, 1'b0, 1);
        add_vec(OP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'hFFF0FFF0, 1'b0, 1);
        add_vec(OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'h0FF00FF0, 1'b0, 1);
        add_vec(OP_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'h000F000F, 1'b0, 1);
        add_vec(OP_SLL,   32'h00000000, 32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0, 1);
        add_vec(OP_SRL,   32'h00000000, 32'h80000000, 5'd31, 1'b0, 32'h00000001, 1'b0, 1);
        add_vec(OP_SLLV,  32'h00000024, 32'h0000000F, 5'd0,  1'b0, 32'h000000F0, 1'b0, 1);
        add_vec(OP_SRAV,  32'h00000021, 32'h80000000, 5'd0,  1'b0, 32'hC0000000, 1'b0, 1);
        add_vec(OP_SRLV,  32'h0000003F, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000001, 1'b0, 1);
        add_vec(5'b00011, 32'hDEADBEEF, 32'h12345678, 5'd0,  1'b1, 32'hDEADBEEF, 1'b0, 1);
        add_vec(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 5'd0,  1'b0, 32'h80000000, 1'b0, 1);
        add_vec(OP_SUB,   32'h80000000, 32'h00000001, 5'd0,  1'b1, 32'h7FFFFFFF, 1'b1, 1);
        add_vec(OP_MULH,  32'hFFFFFFFE, 32'h00000003, 5'd0,  1'b1, 32'hFFFFFFFF, 1'b0, 33);
        add_vec(OP_MULHU, 32'hFFFFFFFE, 32'h00000003, 5'd0,  1'b0, 32'h00000002, 1'b0, 33);
        add_vec(OP_MUL,   32'hFFFFFFFE, 32'h00000003, 5'd0,  1'b0, 32'hFFFFFFFA, 1'b0, 33);
        add_vec(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 5'd0,  1'b0, 32'hFFFFFFFD, 1'b0, 33);
        add_vec(OP_REM,   32'hFFFFFFF9, 32'h00000002, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 33);
        add_vec(OP_DIVU,  32'h00000007, 32'h00000000, 5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1);
        add_vec(OP_REMU,  32'h00000007, 32'h00000000, 5'd0,  1'b0, 32'h00000007, 1'b0, 1);
        add_vec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h80000000, 1'b0, 33);
        add_vec(OP_REM,   32'h80000000, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000000, 1'b0, 33);
        add_vec(OP_DIVU,  32'h00000064, 32'h00000007, 5'd0,  1'b0, 32'h0000000E, 1'b0, 33);
        add_vec(OP_REMU,  32'h00000064, 32'h00000007, 5'd0,  1'b0, 32'h00000002, 1'b0, 33);
        add_vec(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 5'd0,  1'b0, 32'hFFFFFFFD, 1'b0, 33);
        add_vec(OP_REM,   32'h00000007, 32'hFFFFFFFE, 5'd0,  1'b0, 32'h00000001, 1'b0, 33);

        // Reset values
        #2;
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_alu_res",   alu_res,        32'h0);
        check("rst_zero_flag", 32'(zero_flag), 32'h1);
        check("rst_overflow",  32'(overflow),  32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table, issued back-to-back
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end
        @(posedge clk);
        #1;

        // Hold with out_ready low, then back-to-back accept on release
        out_ready = 1'b0;
        v.op = OP_ADD; v.a = 32'h3; v.b = 32'h4; v.sh = 5'd0; v.ovc = 1'b0;
        v.res = 32'h7; v.ovf = 1'b0; v.lat = 1;
        run_op(v);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'h1);
            check("hold_result", alu_res, 32'h7);
        end
        out_ready = 1'b1;
        v.op = OP_XOR; v.a = 32'hFF; v.b = 32'h0F; v.res = 32'hF0;
        run_op(v);
        @(posedge clk);
        #1;

        // Flush in cycle 10 of a DIV
        op_code = OP_DIV; srca = 32'h64; srcb = 32'h3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 32'(in_ready), 32'h1);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush_never_valid", 32'(seen), 32'h0);

        // Flush together with in_valid: nothing accepted
        op_code = OP_ADD; srca = 32'h1; srcb = 32'h1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("flush_accept_valid2", 32'(out_valid), 32'h0);
        check("flush_accept_ready", 32'(in_ready), 32'h1);

        // Reset in the middle of a MUL
        op_code = OP_MUL; srca = 32'h5; srcb = 32'h6; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  32'(in_ready),  32'h1);
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_alu_res",   alu_res,        32'h0);
        check("midrst_zero_flag", 32'(zero_flag), 32'h1);
        check("midrst_overflow",  32'(overflow),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        v.op = OP_ADD; v.a = 32'h1; v.b = 32'h1; v.res = 32'h2; v.lat = 1;
        run_op(v);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
